timebase_generator: RTL

- Programmable tick source that produces the single-cycle external timebase strobe consumed by the enable generator counters (`ext_timebase` input).
- Divides the system clock by a register-set ratio.
- Can be phase-aligned to an asynchronous external sync pulse, so several boards or generators share a common time grid.
- Configured and monitored through an AXI-lite slave using the team's simple register control unit.

---
 rtl/timebase_generator.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/timebase_generator.sv
// Programmable divider tick source, phase-alignable to an async sync pulse, AXI-lite configured.
// Latency: tick_out registered; sync edge acts SYNC_STAGES+1 edges after sync_in rises.
// Backpressure: one outstanding write response and one read response; aw/w accepted together.
module timebase_generator #(
  parameter int COUNTER_WIDTH = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sync_in,
  input  logic        gen_enable_in,
  output logic        tick_out,
  output logic        running,
  input  logic [3:0]  axil_awaddr,
  input  logic        axil_awvalid,
  output logic        axil_awready,
  input  logic [31:0] axil_wdata,
  input  logic [3:0]  axil_wstrb,
  input  logic        axil_wvalid,
  output logic        axil_wready,
  output logic [1:0]  axil_bresp,
  output logic        axil_bvalid,
  input  logic        axil_bready,
  input  logic [3:0]  axil_araddr,
  input  logic        axil_arvalid,
  output logic        axil_arready,
  output logic [31:0] axil_rdata,
  output logic [1:0]  axil_rresp,
  output logic        axil_rvalid,
  input  logic        axil_rready
);

  localparam int CW = COUNTER_WIDTH;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          counter_q, counter_d;
  logic [CW-1:0]          divider_q, divider_d;
  logic [CW-1:0]          phase_q, phase_d;
  logic                   tick_q, tick_d;
  logic [31:0]            tick_count_q, tick_count_d;
  logic [1:0]             ctrl_q, ctrl_d;
  logic [SYNC_STAGES-1:0] sync_pipe_q, sync_pipe_d;
  logic                   sync_prev_q, sync_prev_d;
  logic                   bvalid_q, bvalid_d;
  logic                   rvalid_q, rvalid_d;
  logic [31:0]            rdata_q, rdata_d;

  logic          run, sync_pulse, wr_fire, rd_fire;
  logic [CW-1:0] reload_val;
  logic [31:0]   wr_old, wr_new;
  logic [31:0]   reg_view [4];

  assign reg_view[0] = {30'd0, ctrl_q};
  assign reg_view[1] = 32'(divider_q);
  assign reg_view[2] = 32'(phase_q);
  assign reg_view[3] = tick_count_q;

  assign run        = ctrl_q[0] | gen_enable_in;
  assign sync_pulse = sync_pipe_q[SYNC_STAGES-1] & ~sync_prev_q;
  // A phase beyond the divider clamps, so the very next cycle wraps and ticks.
  assign reload_val = (phase_q > divider_q) ? divider_q : phase_q;
  assign wr_fire    = axil_awvalid & axil_wvalid & ~bvalid_q;
  assign rd_fire    = axil_arvalid & ~rvalid_q;
  assign wr_old     = reg_view[axil_awaddr[3:2]];

  always_comb begin
    wr_new = wr_old;
    for (int b = 0; b < 4; b++) begin
      if (axil_wstrb[b]) wr_new[8*b +: 8] = axil_wdata[8*b +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    tick_d       = 1'b0;
    tick_count_d = tick_count_q;
    case (state_q)
      ST_IDLE: begin
        counter_d    = '0;
        tick_count_d = '0;
        if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!run) begin
          state_d      = ST_IDLE;
          counter_d    = '0;
          tick_count_d = '0;
        end else begin
          tick_count_d = tick_count_q + 32'(tick_q);
          // Sync reload wins over a coincident terminal count; that tick is dropped.
          if (sync_pulse && ctrl_q[1]) begin
            counter_d = reload_val;
          end else if (counter_q >= divider_q) begin
            counter_d = '0;
            tick_d    = 1'b1;
          end else begin
            counter_d = counter_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    divider_d   = divider_q;
    phase_d     = phase_q;
    bvalid_d    = bvalid_q & ~axil_bready;
    rvalid_d    = rvalid_q & ~axil_rready;
    rdata_d     = rdata_q;
    sync_pipe_d = {sync_pipe_q[SYNC_STAGES-2:0], sync_in};
    sync_prev_d = sync_pipe_q[SYNC_STAGES-1];
    if (wr_fire) begin
      bvalid_d = 1'b1;
      if (axil_awaddr[1:0] == 2'b00) begin
        case (axil_awaddr[3:2])
          2'd0:    ctrl_d    = wr_new[1:0];
          2'd1:    divider_d = CW'(wr_new);
          2'd2:    phase_d   = CW'(wr_new);
          default: ;
        endcase
      end
    end
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = (axil_araddr[1:0] == 2'b00) ? reg_view[axil_araddr[3:2]] : 32'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      counter_q    <= '0;
      divider_q    <= '0;
      phase_q      <= '0;
      tick_q       <= 1'b0;
      tick_count_q <= '0;
      ctrl_q       <= '0;
      sync_pipe_q  <= '0;
      sync_prev_q  <= 1'b0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      divider_q    <= divider_d;
      phase_q      <= phase_d;
      tick_q       <= tick_d;
      tick_count_q <= tick_count_d;
      ctrl_q       <= ctrl_d;
      sync_pipe_q  <= sync_pipe_d;
      sync_prev_q  <= sync_prev_d;
      bvalid_q     <= bvalid_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign tick_out     = tick_q;
  assign running      = (state_q == ST_RUN);
  assign axil_awready = wr_fire;
  assign axil_wready  = wr_fire;
  assign axil_bresp   = 2'b00;
  assign axil_bvalid  = bvalid_q;
  assign axil_arready = ~rvalid_q;
  assign axil_rdata   = rdata_q;
  assign axil_rresp   = 2'b00;
  assign axil_rvalid  = rvalid_q;

endmodule
